// File: rtl/sid_envelope_gen.sv
// Purpose : ADSR envelope generator for one SID voice (rate counter, piecewise-exponential decay, zero hold).
// Latency : envelope/state_o update 1 clk after the active edge that steps the envelope or sees a gate edge.
// Backpressure: none; all state advances only on clk edges with active=1 and holds otherwise.
// Option  : define SID_ENV_ADSR_BUG_EN for exact-equality rate ticks (counter wrap-around "ADSR delay bug").
// The release-rate nibble is named release_rate because "release" is a reserved word.

module sid_envelope_gen #(
    parameter int RATE_BITS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic       gate,
    input  logic [3:0] attack,
    input  logic [3:0] decay,
    input  logic [3:0] sustain,
    input  logic [3:0] release_rate,
    output logic [7:0] envelope,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ATTACK        = 2'd0,
        DECAY_SUSTAIN = 2'd1,
        RELEASE       = 2'd2
    } env_state_t;

    env_state_t           state;
    env_state_t           state_next;
    env_state_t           eff_state;

    logic [RATE_BITS-1:0] rate_cnt;
    logic [RATE_BITS-1:0] rate_cnt_next;
    logic [RATE_BITS-1:0] rate_inc;
    logic [RATE_BITS-1:0] period;
    logic [3:0]           rate_sel;

    logic [4:0]           exp_cnt;
    logic [4:0]           exp_cnt_next;
    logic [4:0]           exp_inc;
    logic [4:0]           exp_period;
    logic [4:0]           exp_period_next;

    logic [7:0]           env_next;
    logic                 hold_zero;
    logic                 hold_zero_next;
    logic                 hold_eff;
    logic                 gate_prev;
    logic                 gate_rise;
    logic                 gate_fall;
    logic                 tick;
    logic                 step;

    // Rate index to counter period (number of active cycles between rate ticks).
    function automatic logic [14:0] rate_period(input logic [3:0] idx);
        logic [14:0] p;
        case (idx)
            4'd0:    p = 15'd9;
            4'd1:    p = 15'd32;
            4'd2:    p = 15'd63;
            4'd3:    p = 15'd95;
            4'd4:    p = 15'd149;
            4'd5:    p = 15'd220;
            4'd6:    p = 15'd267;
            4'd7:    p = 15'd313;
            4'd8:    p = 15'd392;
            4'd9:    p = 15'd977;
            4'd10:   p = 15'd1954;
            4'd11:   p = 15'd3126;
            4'd12:   p = 15'd3907;
            4'd13:   p = 15'd11720;
            4'd14:   p = 15'd19532;
            default: p = 15'd31251;
        endcase
        return p;
    endfunction

    // Next-state and datapath: gate edges first, then rate tick, exponential divider and envelope step.
    always_comb begin
        gate_rise       = gate & ~gate_prev;
        gate_fall       = ~gate & gate_prev;

        // A gate edge takes effect in the same cycle, so a coincident step uses the new direction.
        eff_state = state;
        if (gate_rise) begin
            eff_state = ATTACK;
        end else if (gate_fall) begin
            eff_state = RELEASE;
        end

        // Retrigger releases the zero hold so a coincident step can already count up.
        hold_eff = hold_zero & ~gate_rise;

        case (eff_state)
            ATTACK:        rate_sel = attack;
            DECAY_SUSTAIN: rate_sel = decay;
            default:       rate_sel = release_rate;
        endcase
        period   = RATE_BITS'(rate_period(rate_sel));
        rate_inc = rate_cnt + 1'b1;

`ifdef SID_ENV_ADSR_BUG_EN
        // Exact compare: a period lowered below the counter is only hit after a full wrap.
        tick = (rate_inc == period);
`else
        tick = (rate_inc >= period);
`endif
        rate_cnt_next = tick ? '0 : rate_inc;

        // Attack steps on every tick; other states divide ticks by exp_period.
        step         = 1'b0;
        exp_inc      = exp_cnt + 1'b1;
        exp_cnt_next = exp_cnt;
        if (tick) begin
            if (eff_state == ATTACK) begin
                exp_cnt_next = '0;
                step         = 1'b1;
            end else if (exp_inc == exp_period) begin
                exp_cnt_next = '0;
                step         = 1'b1;
            end else begin
                exp_cnt_next = exp_inc;
            end
        end

        env_next       = envelope;
        state_next     = eff_state;
        hold_zero_next = hold_eff;
        if (step && !hold_eff) begin
            case (eff_state)
                ATTACK: begin
                    env_next = envelope + 8'd1;
                    if (env_next == 8'hFF) begin
                        state_next = DECAY_SUSTAIN;
                    end
                end
                DECAY_SUSTAIN: begin
                    if (envelope != {sustain, sustain}) begin
                        env_next = envelope - 8'd1;
                    end
                end
                default: begin
                    env_next = envelope - 8'd1;
                end
            endcase
            if (env_next == 8'h00) begin
                hold_zero_next = 1'b1;
            end
        end

        // Breakpoints of the piecewise-exponential curve, keyed on the new level.
        case (env_next)
            8'hFF:   exp_period_next = 5'd1;
            8'h5D:   exp_period_next = 5'd2;
            8'h36:   exp_period_next = 5'd4;
            8'h1A:   exp_period_next = 5'd8;
            8'h0E:   exp_period_next = 5'd16;
            8'h06:   exp_period_next = 5'd30;
            8'h00:   exp_period_next = 5'd1;
            default: exp_period_next = exp_period;
        endcase
    end

    // State register; reset lands in RELEASE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASE;
        end else if (active) begin
            state <= state_next;
        end
    end

    // Counters, envelope level and gate history, advanced on active cycles only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_cnt   <= '0;
            exp_cnt    <= '0;
            exp_period <= 5'd1;
            envelope   <= 8'h00;
            hold_zero  <= 1'b1;
            gate_prev  <= 1'b0;
        end else if (active) begin
            rate_cnt   <= rate_cnt_next;
            exp_cnt    <= exp_cnt_next;
            exp_period <= exp_period_next;
            envelope   <= env_next;
            hold_zero  <= hold_zero_next;
            gate_prev  <= gate;
        end
    end

    assign state_o = state;

endmodule
